// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants and helpers shared by the fetch stage and its
// neighbours (decode, hazard unit).
//   Xlen        datapath width of the core
//   ImemDepth   default instruction memory depth (entries, power of two)
//   NopInstr    bubble encoding, addi x0,x0,0
//   Opc*        RV32I major opcodes, used by decode and the hazard unit
//   pc_sel_e    next-PC source selected by the fetch stage each cycle
package fetch_stage_pkg;

  localparam int unsigned Xlen      = 32;
  localparam int unsigned ImemDepth = 256;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OpcLoad   = 7'b000_0011;
  localparam logic [6:0] OpcOpImm  = 7'b001_0011;
  localparam logic [6:0] OpcAuipc  = 7'b001_0111;
  localparam logic [6:0] OpcStore  = 7'b010_0011;
  localparam logic [6:0] OpcOp     = 7'b011_0011;
  localparam logic [6:0] OpcLui    = 7'b011_0111;
  localparam logic [6:0] OpcBranch = 7'b110_0011;
  localparam logic [6:0] OpcJalr   = 7'b110_0111;
  localparam logic [6:0] OpcJal    = 7'b110_1111;

  typedef enum logic [1:0] {
    PcSelInc      = 2'b00,
    PcSelHold     = 2'b01,
    PcSelRedirect = 2'b10
  } pc_sel_e;

  // A taken branch squashes the fetch even while the hazard unit is stalling,
  // so redirect has to win over hold.
  function automatic pc_sel_e pc_sel(input logic flush, input logic stall);
    pc_sel_e sel;
    if (flush) begin
      sel = PcSelRedirect;
    end else if (stall) begin
      sel = PcSelHold;
    end else begin
      sel = PcSelInc;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_unit.sv
// fetch_stage_pc_unit: program counter register and next-PC mux.
// The PC is an instruction (word) index kept modulo Depth; only the low
// log2(Depth) bits are stored, so wrap-around and truncation of the redirect
// target fall out of the register width.
//   clk_i     clock
//   rst_i     asynchronous active-high reset, PC -> 0
//   flush_i   redirect to target_i (wins over stall_i)
//   stall_i   hold the PC
//   target_i  redirect target, instruction index; bits above log2(Depth) ignored
//   pc_o      current PC, zero-extended to N bits
module fetch_stage_pc_unit
  import fetch_stage_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned Depth = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         stall_i,
  input  logic [N-1:0] target_i,
  output logic [N-1:0] pc_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw-1:0] pc_q, pc_d;
  pc_sel_e       sel;

  // Target bits above the memory index are deliberately dropped.
  logic unused_target_hi;
  assign unused_target_hi = ^target_i[N-1:Aw];

  assign sel = pc_sel(flush_i, stall_i);

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      PcSelRedirect: pc_d = target_i[Aw-1:0];
      PcSelHold:     pc_d = pc_q;
      PcSelInc:      pc_d = pc_q + Aw'(1);  // natural wrap at Depth
      default:       pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = N'(pc_q);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage pipeline.
// Owns the PC (via fetch_stage_pc_unit) and the IF/ID register. The PC drives
// the instruction memory address combinationally; the returned instruction is
// captured into IF/ID together with its PC and a valid bit.
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   stall          hazard unit: hold PC, IF/ID and fetch_count
//   flush          taken branch in EX: redirect PC, bubble into IF/ID
//   branch_target  redirect target (instruction index), used while flush=1
//   imem_addr      = pc, to the instruction memory
//   imem_instr     instruction read combinationally at imem_addr
//   if_id_pc       PC of the instruction in IF/ID
//   if_id_instr    instruction in IF/ID (NOP for a bubble)
//   if_id_valid    1 = real instruction, 0 = bubble
//   fetch_count    number of valid instructions accepted into IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned  N     = 32,
  parameter int unsigned  DEPTH = 256,
  parameter logic [N-1:0] NOP   = NopInstr
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [N-1:0] branch_target,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] if_id_pc,
  output logic [N-1:0] if_id_instr,
  output logic         if_id_valid,
  output logic [31:0]  fetch_count
);

  logic [N-1:0] pc;
  pc_sel_e      sel;

  logic [N-1:0] if_id_pc_q, if_id_pc_d;
  logic [N-1:0] if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  fetch_stage_pc_unit #(
    .N     (N),
    .Depth (DEPTH)
  ) u_pc_unit (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .stall_i  (stall),
    .target_i (branch_target),
    .pc_o     (pc)
  );

  assign sel = pc_sel(flush, stall);

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    unique case (sel)
      PcSelRedirect: begin
        // Squash whatever was being fetched; count only tracks real instructions.
        if_id_pc_d    = '0;
        if_id_instr_d = NOP;
        if_id_valid_d = 1'b0;
      end
      PcSelHold: begin
      end
      PcSelInc: begin
        if_id_pc_d    = pc;
        if_id_instr_d = imem_instr;
        if_id_valid_d = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized
// flush/stall/reset traffic. A driver updates an abstract model of the fetch
// stage and queues the expected post-edge state; a monitor pops and compares
// after every clock edge.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [DEPTH];

  // Combinational instruction memory.
  assign imem_instr = mem[imem_addr[7:0]];

  fetch_stage #(
    .N     (32),
    .DEPTH (DEPTH),
    .NOP   (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: what the pipeline front-end should look like after an edge.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] count;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int unsigned m_pc;
  int unsigned m_vpc;
  int unsigned m_count;
  logic [31:0] m_instr;
  logic        m_valid;

  task automatic model_reset();
    m_pc    = 0;
    m_vpc   = 0;
    m_count = 0;
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic f, input logic s, input logic [31:0] tgt);
    exp_t e;
    if (f) begin
      m_pc    = tgt % DEPTH;
      m_vpc   = 0;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!s) begin
      m_vpc   = m_pc;
      m_instr = mem[m_pc];
      m_valid = 1'b1;
      m_pc    = (m_pc + 1) % DEPTH;
      m_count = m_count + 1;
    end
    e.pc    = m_vpc;
    e.instr = m_instr;
    e.valid = m_valid;
    e.count = m_count;
    e.addr  = m_pc;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic cycle(input logic f, input logic s, input logic [31:0] tgt);
    flush         = f;
    stall         = s;
    branch_target = tgt;
    model_step(f, s, tgt);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_id_pc"}, if_id_pc, 32'd0);
    chk({tag, "_if_id_instr"}, if_id_instr, NOP);
    chk({tag, "_if_id_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
  endtask

  // Reset held across two edges while other inputs request a flush/stall:
  // reset must win and leave no pending redirect.
  task automatic sync_reset(input logic f, input logic s, input logic [31:0] tgt);
    flush         = f;
    stall         = s;
    branch_target = tgt;
    rst           = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("sync_rst");
    rst   = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    model_reset();
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic async_reset();
    flush = 1'b0;
    stall = 1'b1;
    model_step(1'b0, 1'b1, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    model_reset();
  endtask

  // Monitor: compare the DUT against the queued expectation after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("if_id_pc", if_id_pc, mon_e.pc);
        chk("if_id_instr", if_id_instr, mon_e.instr);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, mon_e.valid});
        chk("fetch_count", fetch_count, mon_e.count);
        chk("imem_addr", imem_addr, mon_e.addr);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    flush         = 1'b0;
    stall         = 1'b0;
    branch_target = 32'd0;
    rst           = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Sequential fetch: if_id_pc 0..7, count reaches 8.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0);

    // Stall while IF/ID holds pc 2, then release.
    sync_reset(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);

    // Flush to 6 while pc=3: bubble, then mem[6].
    sync_reset(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd6);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);

    // Flush wins over stall; out-of-range target is truncated (300 -> 44).
    cycle(1'b1, 1'b1, 32'd1);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd300);
    cycle(1'b0, 1'b0, 32'd0);

    // Run up to pc=255 and across the wrap.
    while (m_pc != DEPTH - 1) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);

    // Asynchronous reset between edges, then reset over a pending flush.
    async_reset();
    cycle(1'b0, 1'b0, 32'd0);
    sync_reset(1'b1, 1'b1, 32'd77);
    cycle(1'b0, 1'b0, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        async_reset();
      end else if (r == 1) begin
        sync_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), $urandom);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
